alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one EX-stage ALU instance between NUM_REQ issue slots of the superscalar front end.
- Each cycle it selects one valid slot round-robin and registers that slot's operand bundle into the ALU input stage.
- The ALU result is captured together with its slot/destination tag into an output register that has valid/ready backpressure.
- Two-stage pipeline: issue register, then result register; synchronous flush.

Parameters:
- NUM_REQ, 2, number of requesting issue slots (2..4).
- ALU_OPC_WIDTH, 12, width of alu_op: {opcode[5:0], funct[5:0]}.
- CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of both pipeline stages.
- req_valid  in  NUM_REQ  slot i has an ALU operation pending.
- req_ready  out  NUM_REQ  slot i's operation accepted this cycle.
- req_A / req_B  in  NUM_REQ*32 each  operands, slot i at [32i+31:32i].
- req_shamt  in  NUM_REQ*5  shift amount.
- req_alu_op  in  NUM_REQ*ALU_OPC_WIDTH  ALU opcode/funct.
- req_dest_reg  in  NUM_REQ*5  destination register.
- req_dest_valid  in  NUM_REQ  destination write enable.
- alu_A, alu_B, alu_shamt, alu_op  out  32/32/5/ALU_OPC_WIDTH  registered stage-1 operands to the ALU.
- alu_result  in  32  combinational ALU result for the current stage-1 operands.
- res_valid  out  1  result register holds a result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  32  captured result.
- res_slot  out  $clog2(NUM_REQ)  originating slot.
- res_dest_reg  out  5  destination register.
- res_dest_valid  out  1  destination write enable.
- conflict_cnt  out  CNT_WIDTH  cycles in which a valid slot lost arbitration.

Behaviour:
- Reset: s1_valid=0, res_valid=0, rr_ptr=0, conflict_cnt=0.
- Reset: alu_A/alu_B/alu_shamt/alu_op=0; res_data/res_slot/res_dest_reg/res_dest_valid=0.
- Reset is honoured mid-operation; in-flight operations are lost.
- Grant: the first valid slot at or after rr_ptr, searching upward with wrap-around. Grant is one-hot or zero and is purely combinational from req_valid and rr_ptr.
- Advance conditions:
  - adv2 = !res_valid | res_ready
  - adv1 = !s1_valid | adv2
- req_ready[i] = grant[i] & adv1 & !flush. At most one bit is set.
- Requesters hold valid and data stable until ready; withdrawal is not permitted.
- Accept (any req_ready bit set):
  - Stage 1 loads the slot's A, B, shamt, alu_op, dest and slot index; s1_valid=1.
  - rr_ptr = granted+1 mod NUM_REQ.
- No accept but adv1: s1_valid=0; operands are don't-care and may hold.
- Stage 2, when adv2 and s1_valid: load alu_result and the tags; res_valid=1.
- Stage 2, when adv2 and !s1_valid: res_valid=0.
- Stage 2, when !adv2: hold all fields.
- Latency: accepted in cycle t, ALU operands valid t+1, res_valid t+2. Throughput is 1 per cycle with res_ready held high.
- Backpressure: res_valid=1 with res_ready=0 holds both stages once stage 1 is full. req_ready then stays 0 and rr_ptr is frozen.
- flush (priority over all else except reset):
  - Next cycle s1_valid=0 and res_valid=0; nothing accepted this cycle.
  - rr_ptr and conflict_cnt unchanged.
  - A result being transferred in the same cycle (res_valid & res_ready) is still considered consumed.
- conflict_cnt increments when at least 2 req_valid bits are set and some req_ready bit is set. It saturates at all-ones and never wraps.
- The ALU result is never used when s1_valid=0.

Test Plan:
- Reset, then slot0 addu (alu_op=12'h021, A=5, B=7, dest=3), res_ready=1 -> req_ready[0] at t; alu_A=5 at t+1; res_valid, res_data=12, res_slot=0, res_dest_reg=3 at t+2.
- Both slots valid continuously for 4 cycles, res_ready=1 -> grants 0,1,0,1; conflict_cnt=4; results return in the same order.
- Slot1 only valid, rr_ptr=0 -> slot1 granted immediately; rr_ptr becomes 0.
- Two ops issued, res_ready=0 for 3 cycles -> res_valid held with the first result, stage 1 holds the second, req_ready=0 and no new grant. Release gives the results in consecutive cycles.
- flush asserted with both stages full and a request pending -> next cycle res_valid=0, s1_valid=0, the request not accepted and re-granted the following cycle.
- conflict_cnt preset near max by 65540 contended cycles -> stays at 16'hFFFF.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - issue-slot, ALU and result bundle of the shared-ALU arbiter
interface alu_arbiter_if #(
  parameter int NUM_REQ       = 2,
  parameter int ALU_OPC_WIDTH = 12
);
  localparam int SLOT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*32-1:0]            req_A;
  logic [NUM_REQ*32-1:0]            req_B;
  logic [NUM_REQ*5-1:0]             req_shamt;
  logic [NUM_REQ*ALU_OPC_WIDTH-1:0] req_alu_op;
  logic [NUM_REQ*5-1:0]             req_dest_reg;
  logic [NUM_REQ-1:0]               req_dest_valid;

  logic [31:0]                      alu_A;
  logic [31:0]                      alu_B;
  logic [4:0]                       alu_shamt;
  logic [ALU_OPC_WIDTH-1:0]         alu_op;
  logic [31:0]                      alu_result;

  logic                             res_valid;
  logic                             res_ready;
  logic [31:0]                      res_data;
  logic [SLOT_W-1:0]                res_slot;
  logic [4:0]                       res_dest_reg;
  logic                             res_dest_valid;

  modport slave (
    input  req_valid, req_A, req_B, req_shamt, req_alu_op, req_dest_reg, req_dest_valid,
    input  alu_result, res_ready,
    output req_ready, alu_A, alu_B, alu_shamt, alu_op,
    output res_valid, res_data, res_slot, res_dest_reg, res_dest_valid
  );

  modport master (
    output req_valid, req_A, req_B, req_shamt, req_alu_op, req_dest_reg, req_dest_valid,
    output alu_result, res_ready,
    input  req_ready, alu_A, alu_B, alu_shamt, alu_op,
    input  res_valid, res_data, res_slot, res_dest_reg, res_dest_valid
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between issue slots, two-stage pipeline
module alu_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int ALU_OPC_WIDTH = 12,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  alu_arbiter_if.slave         bus,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);
  localparam int SLOT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [SLOT_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                     s1_valid_q, s1_valid_d;
  logic [31:0]              alu_a_q, alu_a_d;
  logic [31:0]              alu_b_q, alu_b_d;
  logic [4:0]               alu_shamt_q, alu_shamt_d;
  logic [ALU_OPC_WIDTH-1:0] alu_op_q, alu_op_d;
  logic [SLOT_W-1:0]        s1_slot_q, s1_slot_d;
  logic [4:0]               s1_dest_q, s1_dest_d;
  logic                     s1_dest_valid_q, s1_dest_valid_d;
  logic                     res_valid_q, res_valid_d;
  logic [31:0]              res_data_q, res_data_d;
  logic [SLOT_W-1:0]        res_slot_q, res_slot_d;
  logic [4:0]               res_dest_q, res_dest_d;
  logic                     res_dest_valid_q, res_dest_valid_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0]       grant;
  logic [SLOT_W-1:0]        grant_idx;
  logic                     grant_any;
  logic                     multi_req;
  logic                     adv1, adv2, accept;

  // First valid slot at or after rr_ptr, wrapping upward.
  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!grant_any && bus.req_valid[j]) begin
        grant_any    = 1'b1;
        grant[j]     = 1'b1;
        grant_idx    = SLOT_W'(j);
      end
    end
  end

  always_comb begin
    int n;
    n = 0;
    for (int k = 0; k < NUM_REQ; k++) n = n + int'(bus.req_valid[k]);
    multi_req = (n >= 2);
  end

  assign adv2          = !res_valid_q || bus.res_ready;
  assign adv1          = !s1_valid_q || adv2;
  assign accept        = grant_any && adv1 && !flush;
  assign bus.req_ready = accept ? grant : '0;

  always_comb begin
    int sel;
    sel              = int'(grant_idx);
    rr_ptr_d         = rr_ptr_q;
    s1_valid_d       = s1_valid_q;
    alu_a_d          = alu_a_q;
    alu_b_d          = alu_b_q;
    alu_shamt_d      = alu_shamt_q;
    alu_op_d         = alu_op_q;
    s1_slot_d        = s1_slot_q;
    s1_dest_d        = s1_dest_q;
    s1_dest_valid_d  = s1_dest_valid_q;
    res_valid_d      = res_valid_q;
    res_data_d       = res_data_q;
    res_slot_d       = res_slot_q;
    res_dest_d       = res_dest_q;
    res_dest_valid_d = res_dest_valid_q;
    cnt_d            = cnt_q;

    if (accept) begin
      alu_a_d         = bus.req_A[32*sel +: 32];
      alu_b_d         = bus.req_B[32*sel +: 32];
      alu_shamt_d     = bus.req_shamt[5*sel +: 5];
      alu_op_d        = bus.req_alu_op[ALU_OPC_WIDTH*sel +: ALU_OPC_WIDTH];
      s1_slot_d       = grant_idx;
      s1_dest_d       = bus.req_dest_reg[5*sel +: 5];
      s1_dest_valid_d = bus.req_dest_valid[sel];
      rr_ptr_d        = (grant_idx == SLOT_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      if (multi_req && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    // Flush kills both stages but leaves fairness state and the counter alone.
    if (flush) begin
      s1_valid_d  = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      if (adv1) s1_valid_d = accept;
      if (adv2) begin
        res_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          res_data_d       = bus.alu_result;
          res_slot_d       = s1_slot_q;
          res_dest_d       = s1_dest_q;
          res_dest_valid_d = s1_dest_valid_q;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q         <= '0;
      s1_valid_q       <= 1'b0;
      alu_a_q          <= '0;
      alu_b_q          <= '0;
      alu_shamt_q      <= '0;
      alu_op_q         <= '0;
      s1_slot_q        <= '0;
      s1_dest_q        <= '0;
      s1_dest_valid_q  <= 1'b0;
      res_valid_q      <= 1'b0;
      res_data_q       <= '0;
      res_slot_q       <= '0;
      res_dest_q       <= '0;
      res_dest_valid_q <= 1'b0;
      cnt_q            <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      s1_valid_q       <= s1_valid_d;
      alu_a_q          <= alu_a_d;
      alu_b_q          <= alu_b_d;
      alu_shamt_q      <= alu_shamt_d;
      alu_op_q         <= alu_op_d;
      s1_slot_q        <= s1_slot_d;
      s1_dest_q        <= s1_dest_d;
      s1_dest_valid_q  <= s1_dest_valid_d;
      res_valid_q      <= res_valid_d;
      res_data_q       <= res_data_d;
      res_slot_q       <= res_slot_d;
      res_dest_q       <= res_dest_d;
      res_dest_valid_q <= res_dest_valid_d;
      cnt_q            <= cnt_d;
    end
  end

  assign bus.alu_A          = alu_a_q;
  assign bus.alu_B          = alu_b_q;
  assign bus.alu_shamt      = alu_shamt_q;
  assign bus.alu_op         = alu_op_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_data       = res_data_q;
  assign bus.res_slot       = res_slot_q;
  assign bus.res_dest_reg   = res_dest_q;
  assign bus.res_dest_valid = res_dest_valid_q;
  assign conflict_cnt       = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized bench for alu_arbiter against a cycle-level reference model
module tb_alu_arbiter;
  localparam int N   = 2;
  localparam int OPW = 12;
  localparam int CW  = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] conflict_cnt;

  alu_arbiter_if #(.NUM_REQ(N), .ALU_OPC_WIDTH(OPW)) bus ();

  alu_arbiter #(.NUM_REQ(N), .ALU_OPC_WIDTH(OPW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .bus(bus), .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [4:0] sh, logic [11:0] op);
    case (op[5:0])
      6'h21:   return a + b;
      6'h23:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h00:   return b << sh;
      6'h02:   return b >> sh;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb bus.alu_result = alu_fn(bus.alu_A, bus.alu_B, bus.alu_shamt, bus.alu_op);

  typedef struct {
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [11:0] op;
    logic [4:0]  dest;
    logic        dv;
  } req_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] a;
    logic [11:0] op;
    int          slot;
    logic [4:0]  dest;
    logic        dv;
  } item_t;

  req_t  pend [N];
  bit    pend_v [N];
  item_t m_s1, m_s2;
  bit    m_s1v, m_s2v;
  int    m_rr, m_cnt;
  int    total = 0;
  int    bad = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    logic [5:0] functs [7] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02};
    r.a    = $urandom;
    r.b    = $urandom;
    r.sh   = 5'($urandom_range(31));
    r.op   = {6'h00, functs[$urandom_range(6)]};
    r.dest = 5'($urandom_range(31));
    r.dv   = 1'($urandom_range(1));
    return r;
  endfunction

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]            = pend_v[i];
      bus.req_A[32*i +: 32]       = pend[i].a;
      bus.req_B[32*i +: 32]       = pend[i].b;
      bus.req_shamt[5*i +: 5]     = pend[i].sh;
      bus.req_alu_op[OPW*i +: OPW] = pend[i].op;
      bus.req_dest_reg[5*i +: 5]  = pend[i].dest;
      bus.req_dest_valid[i]       = pend[i].dv;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush = 1'b0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0;
      pend[i] = rand_req();
    end
    pack_inputs();
    m_s1v = 0; m_s2v = 0; m_rr = 0; m_cnt = 0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_slot", bus.res_slot, 0);
    check("rst_alu_A", bus.alu_A, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_cnt", conflict_cnt, 0);
    reset_n = 1'b1;
  endtask

  // One clock: pv/pr/pf are percent chances of new request, res_ready, flush.
  task automatic cycle(int pv, int pr, int pf);
    int g, nv;
    bit adv1, adv2, acc;
    logic [N-1:0] exp_ready;
    @(negedge clock);
    for (int i = 0; i < N; i++)
      if (!pend_v[i] && ($urandom_range(99) < pv)) begin
        pend_v[i] = 1'b1;
        pend[i] = rand_req();
      end
    pack_inputs();
    bus.res_ready = ($urandom_range(99) < pr);
    flush = ($urandom_range(99) < pf);
    #1;
    check("res_valid", bus.res_valid, m_s2v);
    if (m_s2v) begin
      check("res_data", bus.res_data, m_s2.res);
      check("res_slot", bus.res_slot, m_s2.slot);
      check("res_dest", bus.res_dest_reg, m_s2.dest);
      check("res_dv", bus.res_dest_valid, m_s2.dv);
    end
    if (m_s1v) begin
      check("alu_A", bus.alu_A, m_s1.a);
      check("alu_op", bus.alu_op, m_s1.op);
    end
    check("conflict_cnt", conflict_cnt, m_cnt);

    adv2 = !m_s2v || bus.res_ready;
    adv1 = !m_s1v || adv2;
    g = -1;
    nv = 0;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && pend_v[(m_rr + k) % N]) g = (m_rr + k) % N;
      nv += int'(pend_v[k]);
    end
    acc = (g >= 0) && adv1 && !flush;
    exp_ready = '0;
    if (acc) exp_ready[g] = 1'b1;
    check("req_ready", bus.req_ready, exp_ready);

    if (acc && nv >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
    if (flush) begin
      m_s1v = 0;
      m_s2v = 0;
    end else begin
      if (adv2) begin
        m_s2v = m_s1v;
        m_s2 = m_s1;
      end
      if (adv1) begin
        m_s1v = acc;
        if (acc) begin
          m_s1.res  = alu_fn(pend[g].a, pend[g].b, pend[g].sh, pend[g].op);
          m_s1.a    = pend[g].a;
          m_s1.op   = pend[g].op;
          m_s1.slot = g;
          m_s1.dest = pend[g].dest;
          m_s1.dv   = pend[g].dv;
        end
      end
    end
    if (acc) begin
      m_rr = (g + 1) % N;
      pend_v[g] = 1'b0;
    end
  endtask

  initial begin
    do_reset();
    pend[0] = '{a: 32'd5, b: 32'd7, sh: 5'd0, op: 12'h021, dest: 5'd3, dv: 1'b1};
    pend_v[0] = 1'b1;
    cycle(0, 100, 0);
    check("addu_ready", bus.req_ready, 2'b01);
    cycle(0, 100, 0);
    check("addu_alu_A", bus.alu_A, 5);
    cycle(0, 100, 0);
    check("addu_res_valid", bus.res_valid, 1);
    check("addu_res_data", bus.res_data, 12);
    check("addu_res_dest", bus.res_dest_reg, 3);

    do_reset();
    pend_v[1] = 1'b1;
    cycle(0, 100, 0);
    check("slot1_only", bus.req_ready, 2'b10);
    repeat (3) cycle(0, 100, 0);

    do_reset();
    repeat (4) cycle(100, 100, 0);
    repeat (3) cycle(0, 100, 0);
    check("contend_cnt4", conflict_cnt, 4);

    do_reset();
    pend_v[0] = 1'b1;
    pend_v[1] = 1'b1;
    repeat (2) cycle(0, 0, 0);
    pend_v[0] = 1'b1;
    pend[0] = rand_req();
    repeat (3) cycle(0, 0, 0);
    check("bp_no_grant", bus.req_ready, 0);
    cycle(0, 0, 100);
    check("flush_no_accept", bus.req_ready, 0);
    cycle(0, 100, 0);
    check("flush_kill", bus.res_valid, 0);
    check("flush_regrant", bus.req_ready, 2'b01);
    repeat (3) cycle(0, 100, 0);

    do_reset();
    for (int i = 0; i < 3000; i++) cycle(40, 60, 4);

    do_reset();
    for (int i = 0; i < 65540; i++) cycle(100, 100, 0);
    @(negedge clock);
    #1;
    check("cnt_sat", conflict_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
